serializador_paralelo_serial: RTL

// - Parallel-in/serial-out transmitter feeding the serial input ('entrada') of the 4-bit shift register.
// - Accepts a WIDTH-bit word through a valid/ready handshake and shifts it out one bit per clock on 'saida'.
// - Optional idle gap between words; 'fim' flags the last bit of each word.

---
 rtl/serializador_paralelo_serial.sv | 93 +++++++++
 1 files changed

// File: rtl/serializador_paralelo_serial.sv
// Parallel-in/serial-out transmitter: takes a WIDTH-bit word on a valid/ready
// handshake and shifts it out one bit per clock, with an optional idle gap.
module serializador_paralelo_serial #(
  parameter int WIDTH     = 4,
  parameter bit MSB_FIRST = 1'b1,
  parameter int GAP       = 0
) (
  input  logic             clock,
  input  logic             reset,
  input  logic [WIDTH-1:0] dado,
  input  logic             valido,
  output logic             pronto,
  output logic             saida,
  output logic             ativo,
  output logic             fim
);
  localparam int CW = $clog2(WIDTH + 1);
  localparam int GW = (GAP > 0) ? $clog2(GAP + 1) : 1;
  localparam logic [CW-1:0] LAST_BIT = CW'(WIDTH - 1);
  localparam logic [GW-1:0] LAST_GAP = (GAP > 0) ? GW'(GAP - 1) : '0;

  typedef enum logic [1:0] {OCIOSO, TRANSMITINDO, PAUSA} estado_t;

  estado_t          estado, estado_n;
  logic [WIDTH-1:0] sreg, sreg_n, shifted;
  logic [CW-1:0]    cnt, cnt_n;
  logic [GW-1:0]    gcnt, gcnt_n;
  logic             ativo_n, fim_n, aceita;

  // saida is a flop bit of the shift register; zero fill leaves it at 0 once a word is out
  assign shifted = MSB_FIRST ? {sreg[WIDTH-2:0], 1'b0} : {1'b0, sreg[WIDTH-1:1]};
  assign saida   = MSB_FIRST ? sreg[WIDTH-1] : sreg[0];
  assign aceita  = valido && pronto;

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      estado <= OCIOSO;
      sreg   <= '0;
      cnt    <= '0;
      gcnt   <= '0;
      ativo  <= 1'b0;
      fim    <= 1'b0;
    end else begin
      estado <= estado_n;
      sreg   <= sreg_n;
      cnt    <= cnt_n;
      gcnt   <= gcnt_n;
      ativo  <= ativo_n;
      fim    <= fim_n;
    end
  end

  always_comb begin
    estado_n = estado;
    sreg_n   = sreg;
    cnt_n    = cnt;
    gcnt_n   = gcnt;
    unique case (estado)
      OCIOSO: if (aceita) begin
        estado_n = TRANSMITINDO;
        sreg_n   = dado;
        cnt_n    = '0;
      end
      TRANSMITINDO: begin
        sreg_n = shifted;
        if (cnt == LAST_BIT) begin
          cnt_n = '0;
          // aceita can only be high here when GAP==0 (pronto is decoded that way)
          if (aceita)        sreg_n   = dado;
          else if (GAP == 0) estado_n = OCIOSO;
          else begin
            estado_n = PAUSA;
            gcnt_n   = '0;
          end
        end else begin
          cnt_n = cnt + 1'b1;
        end
      end
      PAUSA: begin
        if (gcnt == LAST_GAP) estado_n = OCIOSO;
        else                  gcnt_n   = gcnt + 1'b1;
      end
      default: estado_n = OCIOSO;
    endcase
  end

  always_comb begin
    pronto  = (estado == OCIOSO) ||
              ((GAP == 0) && (estado == TRANSMITINDO) && (cnt == LAST_BIT));
    ativo_n = (estado_n == TRANSMITINDO);
    fim_n   = ativo_n && (cnt_n == LAST_BIT);
  end
endmodule
